// File: rtl/fust_s_pkg.sv
// Shared types for the scalar FU status table: row layout, FU encoding,
// producer tags and the issue bundle, plus the tag-wakeup and age helpers.
package fust_s_pkg;

    localparam int NUM_FU = 3;
    localparam int TAG_W  = 2;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 32;
    localparam int AGE_W  = 2;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        FU_S_ALU    = 2'd0,
        FU_S_LD_ST  = 2'd1,
        FU_S_BRANCH = 2'd2
    } fu_s_t;

    typedef struct packed {
        logic             busy;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
        tag_t             t1;
        tag_t             t2;
    } fust_s_row_t;

    typedef struct packed {
        logic             valid;
        fu_s_t            fu;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } issue_s_t;

    // Tag 0 means "ready", so a zero broadcast never wakes anything.
    function automatic tag_t wake_tag(input tag_t tag, input logic wb_valid, input tag_t wb_tag);
        tag_t res;
        if (wb_valid && (wb_tag != tag_t'(0)) && (tag == wb_tag)) begin
            res = tag_t'(0);
        end else begin
            res = tag;
        end
        return res;
    endfunction

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
        logic [AGE_W-1:0] res;
        if (age == {AGE_W{1'b1}}) begin
            res = age;
        end else begin
            res = age + AGE_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/fust_s_age_arb.sv
// Oldest-first selector over the eligible rows; equal ages resolve to the
// lowest row index. Purely combinational.
module fust_s_age_arb
    import fust_s_pkg::*;
(
    input  logic [NUM_FU-1:0]       elig,
    input  logic [NUM_FU*AGE_W-1:0] ages,
    output logic [NUM_FU-1:0]       grant,
    output logic [1:0]              idx,
    output logic                    any
);

    logic [AGE_W-1:0] best_age_s;
    logic             take_s;

    // Strictly-greater compare while scanning upward keeps the lowest index on ties
    always_comb begin
        grant      = '0;
        idx        = 2'd0;
        any        = 1'b0;
        best_age_s = '0;
        take_s     = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            take_s     = elig[i] && (!any || (ages[i*AGE_W +: AGE_W] > best_age_s));
            idx        = take_s ? 2'(i) : idx;
            best_age_s = take_s ? ages[i*AGE_W +: AGE_W] : best_age_s;
            any        = any | take_s;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            grant[i] = any && (idx == 2'(i));
        end
    end

endmodule

// File: rtl/fust_s_issue.sv
// Scalar functional-unit status table: accepts dispatch writes, clears
// operand tags on writeback, and issues the oldest ready row per cycle.
module fust_s_issue
    import fust_s_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              n_fust_s_en,
    input  logic [1:0]        n_fu_s,
    input  logic [REG_W-1:0]  n_rd,
    input  logic [REG_W-1:0]  n_rs1,
    input  logic [REG_W-1:0]  n_rs2,
    input  logic [IMM_W-1:0]  n_imm,
    input  logic [TAG_W-1:0]  n_t1,
    input  logic [TAG_W-1:0]  n_t2,
    input  logic              flush,
    input  logic              freeze,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [NUM_FU-1:0] ex_ready,
    output logic [NUM_FU-1:0] fust_busy,
    output logic              issue_valid,
    output logic [1:0]        issue_fu,
    output logic [REG_W-1:0]  issue_rd,
    output logic [REG_W-1:0]  issue_rs1,
    output logic [REG_W-1:0]  issue_rs2,
    output logic [IMM_W-1:0]  issue_imm,
    output logic              dispatch_err
);

    fust_s_row_t       row_r   [NUM_FU];
    fust_s_row_t       row_n_s [NUM_FU];
    logic [AGE_W-1:0]  age_r   [NUM_FU];
    logic [AGE_W-1:0]  age_n_s [NUM_FU];
    issue_s_t          issue_r;
    issue_s_t          issue_n_s;
    logic              err_r;
    logic              err_n_s;

    logic [NUM_FU-1:0]       busy_s;
    logic [NUM_FU-1:0]       wr_hit_s;
    logic [NUM_FU-1:0]       wr_go_s;
    logic [NUM_FU-1:0]       elig_s;
    logic [NUM_FU*AGE_W-1:0] ages_s;
    logic                    any_wr_s;
    logic                    issue_go_s;
    logic [NUM_FU-1:0]       arb_grant_s;
    logic [1:0]              arb_idx_s;
    logic                    arb_any_s;

    // Decode the dispatch write and build eligibility from registered state
    always_comb begin
        busy_s   = '0;
        wr_hit_s = '0;
        elig_s   = '0;
        ages_s   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            busy_s[i]   = row_r[i].busy;
            wr_hit_s[i] = n_fust_s_en & ~flush & ~freeze & (n_fu_s == 2'(i));
            elig_s[i]   = row_r[i].busy & (row_r[i].t1 == tag_t'(0)) &
                          (row_r[i].t2 == tag_t'(0)) & ex_ready[i];
            ages_s[i*AGE_W +: AGE_W] = age_r[i];
        end
        wr_go_s    = wr_hit_s & ~busy_s;
        any_wr_s   = |wr_go_s;
        err_n_s    = err_r | (|(wr_hit_s & busy_s));
        issue_go_s = arb_any_s & ~flush & ~freeze;
    end

    fust_s_age_arb u_arb (
        .elig  (elig_s),
        .ages  (ages_s),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Per-row next state: flush beats write, write beats issue, issue beats aging
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            row_n_s[i] = row_r[i];
            age_n_s[i] = age_r[i];
            if (flush) begin
                row_n_s[i].busy = 1'b0;
                row_n_s[i].t1   = tag_t'(0);
                row_n_s[i].t2   = tag_t'(0);
                age_n_s[i]      = '0;
            end else if (wr_go_s[i]) begin
                row_n_s[i].busy = 1'b1;
                row_n_s[i].rd   = n_rd;
                row_n_s[i].rs1  = n_rs1;
                row_n_s[i].rs2  = n_rs2;
                row_n_s[i].imm  = n_imm;
                row_n_s[i].t1   = wake_tag(n_t1, wb_valid, wb_tag);
                row_n_s[i].t2   = wake_tag(n_t2, wb_valid, wb_tag);
                age_n_s[i]      = '0;
            end else if (issue_go_s && arb_grant_s[i]) begin
                row_n_s[i].busy = 1'b0;
                age_n_s[i]      = '0;
            end else if (row_r[i].busy) begin
                row_n_s[i].t1 = wake_tag(row_r[i].t1, wb_valid, wb_tag);
                row_n_s[i].t2 = wake_tag(row_r[i].t2, wb_valid, wb_tag);
                age_n_s[i]    = any_wr_s ? age_inc(age_r[i]) : age_r[i];
            end else begin
                row_n_s[i] = row_r[i];
            end
        end
    end

    // Issue register: payload holds when idle, valid is a single-cycle pulse
    always_comb begin
        issue_n_s       = issue_r;
        issue_n_s.valid = 1'b0;
        if (issue_go_s) begin
            issue_n_s.valid = 1'b1;
            issue_n_s.fu    = fu_s_t'(arb_idx_s);
            issue_n_s.rd    = row_r[arb_idx_s].rd;
            issue_n_s.rs1   = row_r[arb_idx_s].rs1;
            issue_n_s.rs2   = row_r[arb_idx_s].rs2;
            issue_n_s.imm   = row_r[arb_idx_s].imm;
        end else begin
            issue_n_s.valid = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                row_r[i] <= '0;
                age_r[i] <= '0;
            end
            issue_r <= '0;
            err_r   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                row_r[i] <= row_n_s[i];
                age_r[i] <= age_n_s[i];
            end
            issue_r <= issue_n_s;
            err_r   <= err_n_s;
        end
    end

    assign fust_busy    = busy_s;
    assign issue_valid  = issue_r.valid;
    assign issue_fu     = issue_r.fu;
    assign issue_rd     = issue_r.rd;
    assign issue_rs1    = issue_r.rs1;
    assign issue_rs2    = issue_r.rs2;
    assign issue_imm    = issue_r.imm;
    assign dispatch_err = err_r;

endmodule

// File: tb/tb_fust_s_issue.sv
// Scoreboard bench for fust_s_issue: a table-level reference model predicts
// each issue, which a negedge monitor compares against the DUT.
module tb_fust_s_issue;
    import fust_s_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        n_fust_s_en;
    logic [1:0]  n_fu_s;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [31:0] n_imm;
    logic [1:0]  n_t1, n_t2;
    logic        flush, freeze, wb_valid;
    logic [1:0]  wb_tag;
    logic [2:0]  ex_ready;
    logic [2:0]  fust_busy;
    logic        issue_valid;
    logic [1:0]  issue_fu;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic [31:0] issue_imm;
    logic        dispatch_err;

    always #5 CLK = ~CLK;

    fust_s_issue dut (
        .CLK(CLK), .nRST(nRST), .n_fust_s_en(n_fust_s_en), .n_fu_s(n_fu_s),
        .n_rd(n_rd), .n_rs1(n_rs1), .n_rs2(n_rs2), .n_imm(n_imm),
        .n_t1(n_t1), .n_t2(n_t2), .flush(flush), .freeze(freeze),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .ex_ready(ex_ready),
        .fust_busy(fust_busy), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .dispatch_err(dispatch_err)
    );

    typedef struct {
        bit          busy;
        int          rd, rs1, rs2;
        logic [31:0] imm;
        int          t1, t2, age;
    } m_row_t;

    typedef struct {
        int          fu, rd, rs1, rs2;
        logic [31:0] imm;
    } exp_t;

    m_row_t m_cur [3];
    m_row_t m_nxt [3];
    bit     m_err, m_nerr, pend_valid;
    exp_t   pend;
    exp_t   exp_q [$];
    int     vectors = 0;
    int     miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int woken(input int tag);
        return (wb_valid && wb_tag != 2'd0 && tag == int'(wb_tag)) ? 0 : tag;
    endfunction

    // Predict the table after the coming edge from the current inputs
    task automatic model_step();
        int sel, fu;
        bit wrote;
        m_nxt = m_cur; m_nerr = m_err; pend_valid = 0; sel = -1; wrote = 0;
        fu = int'(n_fu_s);
        if (flush) begin
            for (int i = 0; i < 3; i++) begin
                m_nxt[i].busy = 0; m_nxt[i].t1 = 0; m_nxt[i].t2 = 0; m_nxt[i].age = 0;
            end
        end else begin
            if (!freeze)
                for (int i = 0; i < 3; i++)
                    if (m_cur[i].busy && m_cur[i].t1 == 0 && m_cur[i].t2 == 0 && ex_ready[i])
                        if (sel < 0 || m_cur[i].age > m_cur[sel].age) sel = i;
            for (int i = 0; i < 3; i++)
                if (m_cur[i].busy) begin
                    m_nxt[i].t1 = woken(m_cur[i].t1);
                    m_nxt[i].t2 = woken(m_cur[i].t2);
                end
            if (n_fust_s_en && !freeze && fu < 3) begin
                if (m_cur[fu].busy) m_nerr = 1;
                else begin
                    wrote = 1;
                    m_nxt[fu].busy = 1;       m_nxt[fu].rd = int'(n_rd);
                    m_nxt[fu].rs1 = int'(n_rs1); m_nxt[fu].rs2 = int'(n_rs2);
                    m_nxt[fu].imm = n_imm;    m_nxt[fu].age = 0;
                    m_nxt[fu].t1 = woken(int'(n_t1)); m_nxt[fu].t2 = woken(int'(n_t2));
                end
            end
            if (sel >= 0) begin
                pend_valid = 1;
                pend.fu = sel; pend.rd = m_cur[sel].rd; pend.rs1 = m_cur[sel].rs1;
                pend.rs2 = m_cur[sel].rs2; pend.imm = m_cur[sel].imm;
                m_nxt[sel].busy = 0; m_nxt[sel].age = 0;
            end
            if (wrote)
                for (int i = 0; i < 3; i++)
                    if (i != fu && i != sel && m_cur[i].busy)
                        m_nxt[i].age = (m_cur[i].age < 3) ? m_cur[i].age + 1 : 3;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        m_cur = m_nxt;
        m_err = m_nerr;
        if (pend_valid) exp_q.push_back(pend);
        #1;
    endtask

    task automatic idle(input logic [2:0] exr);
        n_fust_s_en = 0; n_fu_s = 0; n_rd = 0; n_rs1 = 0; n_rs2 = 0; n_imm = 0;
        n_t1 = 0; n_t2 = 0; flush = 0; freeze = 0; wb_valid = 0; wb_tag = 0;
        ex_ready = exr;
    endtask

    task automatic wr(input int fu, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input int t1, input int t2);
        n_fust_s_en = 1; n_fu_s = 2'(fu); n_rd = 5'(rd); n_rs1 = 5'(rs1);
        n_rs2 = 5'(rs2); n_imm = imm; n_t1 = 2'(t1); n_t2 = 2'(t2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(fust_busy), 64'd0);
        chk({tag, "_valid"}, 64'(issue_valid), 64'd0);
        chk({tag, "_fu"}, 64'(issue_fu), 64'd0);
        chk({tag, "_rd"}, 64'(issue_rd), 64'd0);
        chk({tag, "_rs1"}, 64'(issue_rs1), 64'd0);
        chk({tag, "_rs2"}, 64'(issue_rs2), 64'd0);
        chk({tag, "_imm"}, 64'(issue_imm), 64'd0);
        chk({tag, "_err"}, 64'(dispatch_err), 64'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic async_reset();
        nRST = 0;
        #1;
        check_zero("async_rst");
        for (int i = 0; i < 3; i++) m_cur[i] = '{0, 0, 0, 0, 32'd0, 0, 0, 0};
        m_err = 0;
        exp_q.delete();
        @(posedge CLK);
        #1;
        nRST = 1;
        idle(3'b000);
    endtask

    // Scoreboard monitor: compares every cycle, away from the active edge
    initial begin
        logic [2:0] eb;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                eb = '0;
                for (int i = 0; i < 3; i++) eb[i] = m_cur[i].busy;
                chk("fust_busy", 64'(fust_busy), 64'(eb));
                chk("dispatch_err", 64'(dispatch_err), 64'(m_err));
                chk("issue_valid", 64'(issue_valid), 64'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (issue_valid === 1'b1) begin
                        chk("issue_fu", 64'(issue_fu), 64'(e.fu));
                        chk("issue_rd", 64'(issue_rd), 64'(e.rd));
                        chk("issue_rs1", 64'(issue_rs1), 64'(e.rs1));
                        chk("issue_rs2", 64'(issue_rs2), 64'(e.rs2));
                        chk("issue_imm", 64'(issue_imm), 64'(e.imm));
                    end
                end
            end
        end
    end

    initial begin
        nRST = 0;
        idle(3'b000);
        for (int i = 0; i < 3; i++) m_cur[i] = '{0, 0, 0, 0, 32'd0, 0, 0, 0};
        m_err = 0;
        #2;
        check_zero("reset");
        @(posedge CLK); @(posedge CLK);
        #1;
        nRST = 1;

        // ALU row, all operands ready: issue two cycles after the write
        idle(3'b111); wr(0, 3, 1, 2, 32'h10, 0, 0); tick();
        idle(3'b111); repeat (3) tick();

        // LD_ST row waits for tag 2, then issues two cycles after the broadcast
        idle(3'b111); wr(1, 4, 5, 6, 32'h20, 2, 0); tick();
        idle(3'b111); repeat (5) tick();
        wb_valid = 1; wb_tag = 2; tick();
        idle(3'b111); repeat (3) tick();

        // BRANCH older than ALU: BRANCH wins once execute units open up
        async_reset();
        idle(3'b000); wr(2, 8, 9, 10, 32'h30, 0, 0); tick();
        idle(3'b000); wr(0, 11, 12, 13, 32'h40, 0, 0); tick();
        idle(3'b000); tick();
        idle(3'b111); repeat (4) tick();

        // Write-time bypass of a tag being broadcast in the same cycle
        idle(3'b111); wr(2, 14, 15, 16, 32'h50, 0, 1); wb_valid = 1; wb_tag = 1; tick();
        idle(3'b111); repeat (3) tick();

        // Flush squashes a pending row and discards a coincident write
        idle(3'b111); wr(0, 17, 18, 19, 32'h60, 3, 1); tick();
        idle(3'b111); tick();
        idle(3'b111); wr(1, 20, 21, 22, 32'h70, 0, 0); flush = 1; tick();
        idle(3'b111); repeat (3) tick();

        // Double write to ALU: sticky error, first row's payload kept
        idle(3'b000); wr(0, 7, 1, 1, 32'hAA, 0, 0); tick();
        idle(3'b000); wr(0, 9, 2, 2, 32'hBB, 0, 0); tick();
        idle(3'b001); repeat (3) tick();
        idle(3'b000); wr(1, 5, 5, 5, 32'hCC, 1, 0); tick();
        idle(3'b000); tick();
        async_reset();

        // Randomised traffic, including freeze, flush and out-of-range targets
        for (int c = 0; c < 600; c++) begin
            if (c == 300) async_reset();
            n_fust_s_en = ($urandom_range(0, 1) == 1);
            n_fu_s = 2'($urandom_range(0, 3));
            n_rd = 5'($urandom); n_rs1 = 5'($urandom); n_rs2 = 5'($urandom);
            n_imm = $urandom;
            n_t1 = 2'($urandom_range(0, 3)); n_t2 = 2'($urandom_range(0, 3));
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_tag = 2'($urandom_range(0, 3));
            ex_ready = 3'($urandom);
            flush = ($urandom_range(0, 29) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle(3'b111); repeat (4) tick();
        @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fust_s_issue.md
Name: fust_s_issue

Overview:
- Scalar functional-unit status table and issue stage. It is the reader/consumer side of the dispatch-to-FUST write interface.
- Holds one row per scalar FU: ALU=0, LD_ST=1, BRANCH=2. Rows are written by dispatch through the n_fust_s_en/n_fu_s/n_fust_s write port.
- Clears operand tags on writeback broadcasts and issues the oldest fully-ready row to its execute unit.
- Exports per-row busy back to dispatch for structural-hazard detection.

Parameters:
- NUM_FU, 3, number of scalar FU rows (index = fu_s encoding)
- TAG_W, 2, producer-tag width; tag 0 means operand ready
- REG_W, 5, scalar register index width
- IMM_W, 32, immediate width
- AGE_W, 2, per-row age counter width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- n_fust_s_en  in  1  dispatch write strobe
- n_fu_s  in  2  target row index
- n_rd / n_rs1 / n_rs2  in  REG_W each  row fields
- n_imm  in  IMM_W  row immediate
- n_t1 / n_t2  in  TAG_W each  producer tags of rs1/rs2
- flush  in  1  squash all rows and the issue register
- freeze  in  1  hold: no writes, no issue
- wb_valid  in  1  writeback tag broadcast valid
- wb_tag  in  TAG_W  completing producer tag
- ex_ready  in  NUM_FU  per-FU execute-accept
- fust_busy  out  NUM_FU  row busy flags to dispatch
- issue_valid  out  1  registered issue pulse
- issue_fu  out  2  issued row index
- issue_rd / issue_rs1 / issue_rs2  out  REG_W  issued fields
- issue_imm  out  IMM_W  issued immediate
- dispatch_err  out  1  sticky: write to busy row

Behaviour:
- Reset (nRST low, async): all rows cleared (busy=0, tags=0, age=0). All outputs 0, including dispatch_err.
- Row write:
  - Happens when n_fust_s_en & ~flush & ~freeze & n_fu_s<NUM_FU & ~busy[n_fu_s].
  - At the edge: busy=1, fields stored, age=0.
  - Every other busy row increments its age, saturating at 2^AGE_W-1.
  - Out-of-range index: write ignored.
  - Write to a busy row: write dropped, dispatch_err set (cleared only by reset).
- Write-time wakeup bypass: if wb_valid and n_t1==wb_tag (nonzero), t1 is stored as 0. Same rule for t2.
- Wakeup:
  - Every cycle, including freeze, any busy row with t1==wb_tag (wb_valid, wb_tag≠0) clears t1. Same for t2.
  - wb_tag==0 has no effect.
  - A wakeup takes effect at the edge, so the row is eligible the following cycle.
- Eligibility: busy & t1==0 & t2==0 & ex_ready[row], evaluated from registered state.
- Selection:
  - Among eligible rows, pick the largest age; ties go to the lowest index.
  - At most one issue per cycle.
  - No issue when freeze or flush.
- Issue:
  - At the edge, the issue register captures the selected row and issue_valid=1 for exactly one cycle. Latency from row write to earliest issue_valid is 2 cycles.
  - The issued row clears busy and age at the same edge. fust_busy drops the cycle after issue.
  - If nothing is selected, issue_valid=0 and the other issue_* outputs hold their last values.
- Simultaneous issue and write to the same row: not possible, because a write requires ~busy. A row freed this edge accepts a write from the next cycle.
- Flush:
  - Flush has priority over write, issue and wakeup.
  - At the edge: all busy, tags and ages cleared, issue_valid=0. dispatch_err is unchanged.
- Freeze: row contents and issue register hold, except that issue_valid is forced to 0 and wakeups still apply.
- fust_busy is driven directly from the row busy registers.

Decomposition:
- Shared datapath package holds:
  - fust_s_row_t (busy, rd, rs1, rs2, imm, t1, t2)
  - fu_s_t encoding (FU_S_ALU=0, FU_S_LD_ST=1, FU_S_BRANCH=2)
  - tag_t
  - issue_s_t, the issue output bundle
- One natural sub-module: fust_s_age_arb. It is combinational oldest-first select over NUM_FU eligible/age vectors and returns a one-hot grant plus index.

Test Plan:
- Write ALU row (rd=3, rs1=1, rs2=2, imm=0x10, t1=t2=0), ex_ready=3'b111 -> fust_busy=3'b001 next cycle; issue_valid=1 with issue_fu=0, issue_rd=3, issue_imm=0x10 one cycle later; busy clears.
- Write LD_ST row with t1=2; hold wb idle 5 cycles -> no issue. Pulse wb_valid, wb_tag=2 -> issue_valid exactly 2 cycles after the pulse, issue_fu=1.
- Write BRANCH at cycle 0 and ALU at cycle 1, both tags=0, ex_ready=0 until cycle 3, then 3'b111 -> BRANCH (age 1) issues first, ALU on the next cycle.
- Write with n_t2=1 while wb_valid=1, wb_tag=1 in the same cycle -> row stored ready and issues at minimum latency.
- Row busy with tags pending; assert flush together with a new n_fust_s_en -> next cycle fust_busy=0, issue_valid=0, and the new write is discarded.
- Write ALU twice without issue (ex_ready=0) -> dispatch_err=1, first row's fields retained. Assert nRST low mid-operation -> all outputs return to 0 asynchronously.
